// File: rtl/universal_shift_register_pkg.sv
// Shared op codes and state encoding for the universal shift register
// and the neighbouring ALU datapath blocks.
package universal_shift_register_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_LOAD = 3'b000;
  localparam logic [OP_W-1:0] OP_SLL  = 3'b001;
  localparam logic [OP_W-1:0] OP_SRL  = 3'b010;
  localparam logic [OP_W-1:0] OP_SRA  = 3'b011;
  localparam logic [OP_W-1:0] OP_ROL  = 3'b100;
  localparam logic [OP_W-1:0] OP_ROR  = 3'b101;
  localparam logic [OP_W-1:0] OP_SIL  = 3'b110;
  localparam logic [OP_W-1:0] OP_SIR  = 3'b111;

  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'h0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'h1;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'h2;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'h3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'h4;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'h5;
  localparam logic [ALU_OP_W-1:0] ALU_SHF = 4'h6;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  function automatic logic is_left(
    input logic [OP_W-1:0] op
  );
    return (op == OP_SLL) || (op == OP_ROL) ||
           (op == OP_SIL);
  endfunction

endpackage

// File: rtl/universal_shift_register_step.sv
// One-bit shift/rotate step: next register value and
// the bit that leaves the register on this step.
module shift_step_n
  import universal_shift_register_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic [OP_W-1:0]  op_i,
  input  logic             serial_in_i,
  output logic [WIDTH-1:0] next_q_o,
  output logic             out_bit_o
);

  // Select the inserted bit and direction for the op.
  always_comb begin
    next_q_o  = q_i;
    out_bit_o = 1'b0;
    unique case (op_i)
      OP_LOAD: begin
        next_q_o  = q_i;
        out_bit_o = 1'b0;
      end
      OP_SLL: begin
        next_q_o  = {q_i[WIDTH-2:0], 1'b0};
        out_bit_o = q_i[WIDTH-1];
      end
      OP_SRL: begin
        next_q_o  = {1'b0, q_i[WIDTH-1:1]};
        out_bit_o = q_i[0];
      end
      OP_SRA: begin
        next_q_o  = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
        out_bit_o = q_i[0];
      end
      OP_ROL: begin
        next_q_o  = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
        out_bit_o = q_i[WIDTH-1];
      end
      OP_ROR: begin
        next_q_o  = {q_i[0], q_i[WIDTH-1:1]};
        out_bit_o = q_i[0];
      end
      OP_SIL: begin
        next_q_o  = {q_i[WIDTH-2:0], serial_in_i};
        out_bit_o = q_i[WIDTH-1];
      end
      OP_SIR: begin
        next_q_o  = {serial_in_i, q_i[WIDTH-1:1]};
        out_bit_o = q_i[0];
      end
    endcase
  end

endmodule

// File: rtl/universal_shift_register.sv
// Iterative multi-mode shift register: one bit position
// per clock, start/busy/done handshake.
module universal_shift_register
  import universal_shift_register_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [OP_W-1:0]    op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   load_data,
  input  logic               serial_in,
  output logic [WIDTH-1:0]   q,
  output logic               shifted_out,
  output logic               busy,
  output logic               done,
  output logic               zero
);

  state_e             state_q, state_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               so_q, so_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   step_q;
  logic               step_bit;

  shift_step_n #(
    .WIDTH (WIDTH)
  ) u_step (
    .q_i         (q_q),
    .op_i        (op_q),
    .serial_in_i (serial_in),
    .next_q_o    (step_q),
    .out_bit_o   (step_bit)
  );

  // Next-state: accept work in IDLE, step once per edge in SHIFT.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    q_d     = q_q;
    so_d    = so_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (op == OP_LOAD) begin
            q_d    = load_data;
            done_d = 1'b1;
          end else if (shamt == '0) begin
            done_d = 1'b1;
          end else begin
            op_d    = op;
            count_d = shamt;
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        q_d     = step_q;
        so_d    = step_bit;
        count_d = count_q - SHAMT_W'(1);
        if (count_q == SHAMT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      op_q    <= OP_LOAD;
      q_q     <= '0;
      so_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      q_q     <= q_d;
      so_q    <= so_d;
      done_q  <= done_d;
    end
  end

  assign q           = q_q;
  assign shifted_out = so_q;
  assign busy        = (state_q == ST_SHIFT);
  assign done        = done_q;
  assign zero        = ~|q_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Scoreboard bench for universal_shift_register
// (WIDTH=8, SHAMT_W=4).
module tb_universal_shift_register;
  import universal_shift_register_pkg::*;

  localparam int W = 8;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [2:0]    op;
  logic [SW-1:0] shamt;
  logic [W-1:0]  load_data;
  logic          serial_in;
  logic [W-1:0]  q;
  logic          shifted_out;
  logic          busy;
  logic          done;
  logic          zero;

  universal_shift_register #(
    .WIDTH   (W),
    .SHAMT_W (SW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .shamt       (shamt),
    .load_data   (load_data),
    .serial_in   (serial_in),
    .q           (q),
    .shifted_out (shifted_out),
    .busy        (busy),
    .done        (done),
    .zero        (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic         so;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           cyc = 0;
  logic [W-1:0] mq;
  logic         mso;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  // Closed-form result of n single-bit steps.
  function automatic void model(
    input  logic [2:0]   o,
    input  int           n,
    input  logic [W-1:0] q0,
    input  logic         so0,
    input  logic [W-1:0] ld,
    input  logic [15:0]  bits,
    output logic [W-1:0] nq,
    output logic         nso
  );
    logic [63:0] l;
    int r;
    nq  = q0;
    nso = so0;
    l   = '0;
    r   = n % W;
    if (o == OP_LOAD) begin
      nq = ld;
    end else if (n != 0) begin
      case (o)
        OP_SLL, OP_SIL: begin
          l = 64'(q0) << n;
          if (o == OP_SIL)
            for (int k = 0; k < n; k++)
              l[n-1-k] = bits[k];
          nq  = l[W-1:0];
          nso = l[W];
        end
        OP_SRL, OP_SRA, OP_SIR: begin
          l = 64'(q0);
          for (int k = 0; k < n; k++)
            l[W+k] = (o == OP_SRA) ? q0[W-1] :
                     (o == OP_SIR) ? bits[k] : 1'b0;
          nso = l[n-1];
          l   = l >> n;
          nq  = l[W-1:0];
        end
        OP_ROL: begin
          nq  = 8'((16'(q0) << r) | (16'(q0) >> (W - r)));
          nso = nq[0];
        end
        default: begin
          nq  = 8'((16'(q0) >> r) | (16'(q0) << (W - r)));
          nso = nq[W-1];
        end
      endcase
    end
  endfunction

  // Monitor: every done pulse must match the queue head.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_done: got 1 expected 0 (t=%0t)",
                 $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("q", 32'(q), 32'(e.q));
        chk("shifted_out", 32'(shifted_out), 32'(e.so));
        chk("zero", 32'(zero), 32'(e.q == '0));
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic run_op(input logic [2:0]    o,
                        input logic [SW-1:0] n,
                        input logic [W-1:0]  ld,
                        input logic [15:0]   bits,
                        input bit            noise);
    exp_t e;
    logic [W-1:0] nq;
    logic nso;
    int ne;
    model(o, int'(n), mq, mso, ld, bits, nq, nso);
    ne    = (o == OP_LOAD) ? 0 : int'(n);
    e.q   = nq;
    e.so  = nso;
    e.cyc = cyc + 1 + ne;
    sb.push_back(e);
    mq  = nq;
    mso = nso;
    start     = 1'b1;
    op        = o;
    shamt     = n;
    load_data = ld;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < ne; k++) begin
      chk("busy", 32'(busy), 32'(1));
      serial_in = bits[k];
      start     = noise && ($urandom_range(0, 2) == 0);
      op        = 3'($urandom);
      shamt     = SW'($urandom);
      load_data = W'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    chk("busy_end", 32'(busy), 32'(0));
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    op        = OP_LOAD;
    shamt     = '0;
    load_data = '0;
    serial_in = 1'b0;
    mq        = '0;
    mso       = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_q", 32'(q), 32'(0));
    chk("rst_so", 32'(shifted_out), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_zero", 32'(zero), 32'(1));
    reset = 1'b0;
    @(negedge clk);

    run_op(OP_LOAD, 4'd0, 8'hB4, 16'h0, 1'b0);
    run_op(OP_SRA, 4'd3, 8'h00, 16'h0, 1'b0);
    run_op(OP_LOAD, 4'd0, 8'h81, 16'h0, 1'b0);
    run_op(OP_ROL, 4'd9, 8'h00, 16'h0, 1'b1);
    run_op(OP_LOAD, 4'd0, 8'h00, 16'h0, 1'b0);
    run_op(OP_SIL, 4'd4, 8'h00, 16'h000D, 1'b0);
    run_op(OP_LOAD, 4'd0, 8'hFF, 16'h0, 1'b0);
    run_op(OP_SLL, 4'd8, 8'h00, 16'h0, 1'b0);
    run_op(OP_SRL, 4'd0, 8'h00, 16'h0, 1'b0);
    chk("srl0_q", 32'(q), 32'(0));
    chk("srl0_so", 32'(shifted_out), 32'(1));

    run_op(OP_LOAD, 4'd0, 8'hF0, 16'h0, 1'b0);
    start = 1'b1;
    op    = OP_SRL;
    shamt = 4'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("busy3", 32'(busy), 32'(1));
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_q", 32'(q), 32'(0));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_done", 32'(done), 32'(0));
    chk("mid_rst_so", 32'(shifted_out), 32'(0));
    reset = 1'b0;
    mq    = '0;
    mso   = 1'b0;
    run_op(OP_LOAD, 4'd0, 8'h5A, 16'h0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      run_op(3'($urandom), SW'($urandom_range(0, 15)),
             W'($urandom), 16'($urandom), 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
